// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature-decoder signal chain: default
// position width, velocity-meter state encoding and a signed saturation
// helper that other motor-control blocks can reuse.
package qdec_pkg;

  localparam int DEFAULT_POS_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Result of a saturation: clamped value (sign-extended to 64 bits) plus
  // a flag telling whether clamping happened.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } sat_result_t;

  // Clamp a signed 64-bit value into the signed range of 'width' bits
  // (1 <= width <= 64). The result stays sign-extended to 64 bits so the
  // caller can take the low 'width' bits.
  function automatic sat_result_t saturate_signed(input logic signed [63:0] value,
                                                  input int unsigned        width);
    sat_result_t        res;
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    max_val   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val   = -(64'sd1 <<< (width - 1));
    res.sat   = 1'b0;
    res.value = value;
    if (value > max_val) begin
      res.sat   = 1'b1;
      res.value = max_val;
    end else if (value < min_val) begin
      res.sat   = 1'b1;
      res.value = min_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/qdec_velocity_meter_tick_gen.sv
// Sample-period counter: counts 0..PERIOD_CYCLES-1 while enabled and
// flags the last cycle of each period with 'tick'. Held at 0 when disabled.
module sample_tick_gen #(
  parameter  int PERIOD_CYCLES = 50000,
  localparam int CNT_WIDTH     = $clog2(PERIOD_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PERIOD_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count;

  assign tick = en && (count == LAST);

  // Period counter: clears when disabled, wraps after the tick cycle.
  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/qdec_velocity_meter.sv
// Velocity meter: samples the decoder position once per period, outputs the
// wrap-safe per-period delta saturated to VEL_WIDTH on a valid/ready port,
// and records a sticky overrun when an unread sample is overwritten.
module qdec_velocity_meter
  import qdec_pkg::*;
#(
  parameter int POS_WIDTH     = DEFAULT_POS_WIDTH,
  parameter int VEL_WIDTH     = 16,
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [POS_WIDTH-1:0] position,
  output logic [VEL_WIDTH-1:0] vel,
  output logic                 vel_valid,
  input  logic                 vel_ready,
  output logic                 vel_sat,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  state_t state;
  state_t state_next;

  logic run_en;
  logic tick;
  logic prime_tick;
  logic sample_tick;
  logic xfer;

  logic        [POS_WIDTH-1:0] prev_pos;
  logic signed [POS_WIDTH-1:0] delta;
  logic signed [63:0]          delta_wide;
  sat_result_t                 sat_res;
  logic        [VEL_WIDTH-1:0] vel_next;

  // Counter runs only while measuring; dropping en clears it immediately.
  assign run_en = en && (state != ST_IDLE);

  sample_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .tick(tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: PRIME spends one period capturing a reference position.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (en) state_next = ST_PRIME;
      ST_PRIME: if (!en) state_next = ST_IDLE; else if (tick) state_next = ST_RUN;
      ST_RUN:   if (!en) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: which kind of tick this is.
  always_comb begin
    prime_tick  = 1'b0;
    sample_tick = 1'b0;
    case (state)
      ST_PRIME: prime_tick  = tick;
      ST_RUN:   sample_tick = tick;
      default: ;
    endcase
  end

  // Modulo subtraction reinterpreted as signed handles decoder wrap-around.
  assign delta      = position - prev_pos;
  assign delta_wide = 64'(delta);
  assign sat_res    = saturate_signed(delta_wide, VEL_WIDTH);
  assign vel_next   = sat_res.value[VEL_WIDTH-1:0];

  assign xfer = vel_valid && vel_ready;

  // Reference position: refreshed on every tick, in PRIME and RUN alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pos <= '0;
    end else if (prime_tick || sample_tick) begin
      prev_pos <= position;
    end
  end

  // Output sample: loads on a RUN tick, otherwise held stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vel     <= '0;
      vel_sat <= 1'b0;
    end else if (sample_tick) begin
      vel     <= vel_next;
      vel_sat <= sat_res.sat;
    end
  end

  // Valid flag: a new sample wins over a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vel_valid <= 1'b0;
    end else if (sample_tick) begin
      vel_valid <= 1'b1;
    end else if (xfer) begin
      vel_valid <= 1'b0;
    end
  end

  // Sticky overrun: set on overwrite of an unread sample, set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (sample_tick && vel_valid && !vel_ready) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  // The clamped value must be exactly representable in VEL_WIDTH bits.
  assert property (@(posedge clk) disable iff (rst)
                   sat_res.value == 64'(signed'(vel_next)));

endmodule
